core_hazard_mc: RTL and testbench

Multi-channel successor to the core hazard unit: combines load-use stall detection with a registered handshake sequencer for NUM_CH memory-mapped peripheral channels above PERIPHERAL_BASE. Sits beside the EX/MEM stage, drives the pipeline stall lines, and holds a one-hot per-channel request until the channel answers. Adds wait-state tracking, bus-error reporting and optional timeout.

---
 rtl/core_hazard_mc_pkg.sv | 24 ++
 rtl/core_hazard_mc_if.sv | 33 +++
 rtl/core_hazard_mc_timeout.sv | 28 ++
 rtl/core_hazard_mc.sv | 134 +++++++++++++
 tb/tb_core_hazard_mc.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_hazard_mc_pkg.sv
// Shared types and helpers for the multi-channel hazard / peripheral handshake unit.
package core_hazard_mc_pkg;

  // Sequencer states: idle, waiting on a channel, holding an already-served load-use.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } state_e;

  // Width of a channel index; at least one bit so a single channel still has a vector.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Load-use hazard: a load writing a non-zero register the decoding instruction reads.
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] w_reg,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
    return mem_read && (w_reg != 5'd0) && ((rs == w_reg) || (rt == w_reg));
  endfunction

endpackage

// File: rtl/core_hazard_mc_if.sv
// Pipeline and peripheral-bus signals seen by the hazard unit.
// master: the hazard unit (issues d_valid, drives stalls); slave: pipeline/peripheral side.
interface core_hazard_mc_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned NUM_CH = 4
);
  logic [4:0]        IF_rs;
  logic [4:0]        IF_rt;
  logic [4:0]        EX_W_regnum;
  logic [4:0]        ID_W_regnum;
  logic              ID_mem_read;
  logic              EX_mem_read;
  logic              EX_mem_write;
  logic [ADDR_W-1:0] addr;
  logic [NUM_CH-1:0] d_ready;
  logic [NUM_CH-1:0] d_valid;
  logic              stall_EX;
  logic              stall_ID;
  logic              bus_err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    input  IF_rs, IF_rt, EX_W_regnum, ID_W_regnum, ID_mem_read, EX_mem_read, EX_mem_write,
    input  addr, d_ready,
    output d_valid, stall_EX, stall_ID, bus_err, err_addr
  );

  modport slave (
    output IF_rs, IF_rt, EX_W_regnum, ID_W_regnum, ID_mem_read, EX_mem_read, EX_mem_write,
    output addr, d_ready,
    input  d_valid, stall_EX, stall_ID, bus_err, err_addr
  );
endinterface

// File: rtl/core_hazard_mc_timeout.sv
// WAIT-state watchdog: cleared on entry to WAIT, counts each WAIT cycle and
// flags expiry on the last allowed cycle (count == Cycles-1).
module core_hazard_mc_timeout #(
  parameter int unsigned Cycles = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CntW = $clog2(Cycles);

  logic [CntW-1:0] cnt_q;

  assign expired_o = en_i && (cnt_q == CntW'(Cycles - 1));

  // Count WAIT cycles, holding at the expiry value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/core_hazard_mc.sv
// Load-use stall detection plus a one-hot request sequencer for NUM_CH peripheral
// channels mapped above PERIPHERAL_BASE. Optional WAIT timeout under CORE_HAZARD_TIMEOUT_EN.
module core_hazard_mc
  import core_hazard_mc_pkg::*;
#(
  parameter int unsigned ADDR_W          = 64,
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CH_SPAN_LOG2    = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input logic              clk,
  input logic              reset,
  core_hazard_mc_if.master bus
);
  localparam int unsigned       ChW  = ch_idx_w(NUM_CH);
  localparam logic [ADDR_W-1:0] Base = PERIPHERAL_BASE[ADDR_W-1:0];

  state_e            state_q;
  logic [ChW-1:0]    cur_ch_q;
  logic              bus_err_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic              lu_ex, lu_id;
  logic              req, mapped;
  logic [ADDR_W-1:0] off, ch_full;
  logic [ChW-1:0]    ch;
  logic              rdy_ch, rdy_cur;
  logic              tmo_hit;
  logic              stall_ex;
  logic [NUM_CH-1:0] dvalid;

  assign lu_ex = load_use(bus.EX_mem_read, bus.EX_W_regnum, bus.IF_rs, bus.IF_rt);
  assign lu_id = load_use(bus.ID_mem_read, bus.ID_W_regnum, bus.IF_rs, bus.IF_rt);

  assign req     = (bus.EX_mem_read || bus.EX_mem_write) && (bus.addr >= Base);
  assign off     = bus.addr - Base;
  assign ch_full = off >> CH_SPAN_LOG2;
  assign mapped  = ch_full < ADDR_W'(NUM_CH);
  assign ch      = ch_full[ChW-1:0];
  assign rdy_ch  = bus.d_ready[ch];
  assign rdy_cur = bus.d_ready[cur_ch_q];

`ifdef CORE_HAZARD_TIMEOUT_EN
  logic tmo_expired;

  core_hazard_mc_timeout #(
    .Cycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    ((state_q == StIdle) && req && mapped && !rdy_ch),
    .en_i     (state_q == StWait),
    .expired_o(tmo_expired)
  );

  // Ready in the final cycle wins over expiry.
  assign tmo_hit = tmo_expired && !rdy_cur;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  // Sequencer state, channel latch and registered error reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_ch_q   <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (!mapped) begin
              bus_err_q  <= 1'b1;
              err_addr_q <= bus.addr;
              state_q    <= lu_ex ? StHold : StIdle;
            end else if (rdy_ch) begin
              state_q <= lu_ex ? StHold : StIdle;
            end else begin
              cur_ch_q <= ch;
              state_q  <= StWait;
            end
          end
        end
        StWait: begin
          if (rdy_cur) begin
            state_q <= lu_ex ? StHold : StIdle;
          end else if (tmo_hit) begin
            bus_err_q  <= 1'b1;
            err_addr_q <= bus.addr;
            state_q    <= lu_ex ? StHold : StIdle;
          end
        end
        StHold: begin
          // The EX access was already served; wait for the load-use to clear.
          if (!lu_ex) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request and stall decode; requests are suppressed while reset is asserted.
  always_comb begin
    dvalid   = '0;
    stall_ex = lu_ex;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (req && mapped) begin
            dvalid[ch] = 1'b1;
            if (!rdy_ch) stall_ex = 1'b1;
          end
        end
        StWait: begin
          dvalid[cur_ch_q] = 1'b1;
          if (!rdy_cur && !tmo_hit) stall_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.d_valid  = dvalid;
  assign bus.stall_EX = stall_ex;
  assign bus.stall_ID = stall_ex || lu_id;
  assign bus.bus_err  = bus_err_q;
  assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_core_hazard_mc.sv
// Directed bench for core_hazard_mc; honours CORE_HAZARD_TIMEOUT_EN (runs with 8-cycle timeout).
module tb_core_hazard_mc;
`ifdef CORE_HAZARD_TIMEOUT_EN
  localparam int unsigned TmoCycles = 8;
`else
  localparam int unsigned TmoCycles = 256;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   hs_cnt;

  core_hazard_mc_if #(.ADDR_W(64), .NUM_CH(4)) bus ();

  core_hazard_mc #(
    .ADDR_W         (64),
    .PERIPHERAL_BASE(64'h2000_0000),
    .NUM_CH         (4),
    .CH_SPAN_LOG2   (12),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed handshakes (valid and ready on the same edge).
  always @(posedge clk) begin
    if (|(bus.d_valid & bus.d_ready)) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.IF_rs        = 5'd0;
    bus.IF_rt        = 5'd0;
    bus.EX_W_regnum  = 5'd0;
    bus.ID_W_regnum  = 5'd0;
    bus.ID_mem_read  = 1'b0;
    bus.EX_mem_read  = 1'b0;
    bus.EX_mem_write = 1'b0;
    bus.addr         = 64'd0;
    bus.d_ready      = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int errs;
    int hs0;
    n_chk  = 0;
    n_err  = 0;
    hs_cnt = 0;
    idle_inputs();
    reset = 1'b1;
    #3;
    check("rst_dvalid", 64'(bus.d_valid), 64'h0);
    check("rst_stall_ex", 64'(bus.stall_EX), 64'h0);
    check("rst_stall_id", 64'(bus.stall_ID), 64'h0);
    check("rst_bus_err", 64'(bus.bus_err), 64'h0);
    check("rst_err_addr", bus.err_addr, 64'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Load-use detection (address below peripheral space: no request).
    tick();
    bus.EX_mem_read = 1'b1; bus.EX_W_regnum = 5'd5; bus.IF_rs = 5'd5;
    #1;
    check("lu_ex_stall_ex", 64'(bus.stall_EX), 64'h1);
    check("lu_ex_stall_id", 64'(bus.stall_ID), 64'h1);
    check("lu_ex_no_dvalid", 64'(bus.d_valid), 64'h0);
    bus.EX_W_regnum = 5'd0;
    #1;
    check("lu_r0_stall_ex", 64'(bus.stall_EX), 64'h0);
    check("lu_r0_stall_id", 64'(bus.stall_ID), 64'h0);
    idle_inputs();
    bus.ID_mem_read = 1'b1; bus.ID_W_regnum = 5'd7; bus.IF_rt = 5'd7;
    #1;
    check("lu_id_stall_ex", 64'(bus.stall_EX), 64'h0);
    check("lu_id_stall_id", 64'(bus.stall_ID), 64'h1);

    // Zero-wait write to channel 1.
    tick();
    idle_inputs();
    hs0 = hs_cnt;
    bus.EX_mem_write = 1'b1; bus.addr = 64'h2000_1004; bus.d_ready = 4'b0010;
    #1;
    check("zw_dvalid", 64'(bus.d_valid), 64'h2);
    check("zw_stall", 64'(bus.stall_EX), 64'h0);
    tick();
    idle_inputs();
    #1;
    check("zw_dvalid_after", 64'(bus.d_valid), 64'h0);
    check("zw_no_err", 64'(bus.bus_err), 64'h0);
    check("zw_handshakes", 64'(hs_cnt - hs0), 64'd1);

    // Three wait states on channel 3; addr wobble and a foreign ready are ignored.
    tick();
    bus.EX_mem_read = 1'b1; bus.addr = 64'h2000_3000;
    #1;
    check("w3_c0_stall", 64'(bus.stall_EX), 64'h1);
    check("w3_c0_dvalid", 64'(bus.d_valid), 64'h8);
    tick();
    bus.addr = 64'h2000_1000;
    #1;
    check("w3_c1_stall", 64'(bus.stall_EX), 64'h1);
    check("w3_c1_dvalid", 64'(bus.d_valid), 64'h8);
    tick();
    bus.d_ready = 4'b0010;
    #1;
    check("w3_c2_stall", 64'(bus.stall_EX), 64'h1);
    check("w3_c2_dvalid", 64'(bus.d_valid), 64'h8);
    tick();
    bus.d_ready = 4'b1000;
    #1;
    check("w3_rdy_stall", 64'(bus.stall_EX), 64'h0);
    check("w3_rdy_dvalid", 64'(bus.d_valid), 64'h8);
    tick();
    idle_inputs();
    #1;
    check("w3_idle_dvalid", 64'(bus.d_valid), 64'h0);
    check("w3_idle_stall", 64'(bus.stall_EX), 64'h0);

    // Unmapped access (channel 5) then back-to-back errors.
    tick();
    bus.EX_mem_read = 1'b1; bus.addr = 64'h2000_5000;
    #1;
    check("um_dvalid", 64'(bus.d_valid), 64'h0);
    check("um_stall", 64'(bus.stall_EX), 64'h0);
    check("um_err_not_yet", 64'(bus.bus_err), 64'h0);
    tick();
    idle_inputs();
    #1;
    check("um_err_pulse", 64'(bus.bus_err), 64'h1);
    check("um_err_addr", bus.err_addr, 64'h2000_5000);
    tick();
    bus.EX_mem_write = 1'b1; bus.addr = 64'h2000_6000;
    #1;
    check("um_err_single", 64'(bus.bus_err), 64'h0);
    tick();
    bus.addr = 64'h2000_7000;
    #1;
    check("b2b_err1", 64'(bus.bus_err), 64'h1);
    check("b2b_addr1", bus.err_addr, 64'h2000_6000);
    tick();
    idle_inputs();
    #1;
    check("b2b_err2", 64'(bus.bus_err), 64'h1);
    check("b2b_addr2", bus.err_addr, 64'h2000_7000);
    tick();
    #1;
    check("b2b_err_clear", 64'(bus.bus_err), 64'h0);

    // Channel 2 never answers.
    tick();
    bus.EX_mem_read = 1'b1; bus.addr = 64'h2000_2000;
    n = 0;
    errs = 0;
`ifdef CORE_HAZARD_TIMEOUT_EN
    #1;
    while (bus.stall_EX && n < 20) begin
      n++;
      tick();
      #1;
    end
    check("tmo_stall_cycles", 64'(n), 64'd8);
    check("tmo_last_dvalid", 64'(bus.d_valid), 64'h4);
    tick();
    idle_inputs();
    #1;
    check("tmo_err", 64'(bus.bus_err), 64'h1);
    check("tmo_err_addr", bus.err_addr, 64'h2000_2000);
    check("tmo_dvalid_low", 64'(bus.d_valid), 64'h0);
`else
    for (int i = 0; i < 120; i++) begin
      #1;
      if (bus.stall_EX) n++;
      if (bus.bus_err) errs++;
      tick();
    end
    #1;
    check("nt_stall_cycles", 64'(n), 64'd120);
    check("nt_no_err", 64'(errs), 64'd0);
    check("nt_dvalid", 64'(bus.d_valid), 64'h4);
    reset = 1'b1;
    #1;
    check("nt_rst_dvalid", 64'(bus.d_valid), 64'h0);
    check("nt_rst_stall", 64'(bus.stall_EX), 64'h0);
    idle_inputs();
    tick();
    reset = 1'b0;
`endif

    // Zero-wait completion while load-use persists: HOLD blocks a second access.
    tick();
    idle_inputs();
    hs0 = hs_cnt;
    bus.EX_mem_read = 1'b1; bus.addr = 64'h2000_0000; bus.EX_W_regnum = 5'd9;
    bus.IF_rs = 5'd9; bus.d_ready = 4'b0001;
    #1;
    check("hold_c0_dvalid", 64'(bus.d_valid), 64'h1);
    check("hold_c0_stall", 64'(bus.stall_EX), 64'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("hold_dvalid", 64'(bus.d_valid), 64'h0);
      check("hold_stall", 64'(bus.stall_EX), 64'h1);
    end
    tick();
    bus.IF_rs = 5'd0;
    #1;
    check("hold_rel_dvalid", 64'(bus.d_valid), 64'h0);
    check("hold_rel_stall", 64'(bus.stall_EX), 64'h0);
    tick();
    idle_inputs();
    #1;
    check("hold_handshakes", 64'(hs_cnt - hs0), 64'd1);

    // Reset asserted mid-WAIT drops the request at once.
    tick();
    bus.EX_mem_write = 1'b1; bus.addr = 64'h2000_0010;
    tick();
    tick();
    #1;
    check("rw_wait_dvalid", 64'(bus.d_valid), 64'h1);
    reset = 1'b1;
    #1;
    check("rw_rst_dvalid", 64'(bus.d_valid), 64'h0);
    check("rw_rst_stall", 64'(bus.stall_EX), 64'h0);
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
    check("rw_after_dvalid", 64'(bus.d_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
